wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers; address width is log2(NUM_REGS) = 5.
REQ-002 Parameter DATA_W, default 32: register and datapath width in bits.
REQ-003 CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLOCK.
REQ-005 RegWriteEN_In  input  1  write-back enable, from the MEM/WB stage register.
REQ-006 Mem2RegSEL_In  input  2  write-back source select: 00 ALU, 01 memory, 10 link, 11 reserved.
REQ-007 ALUResult_In  input  DATA_W  ALU result carried through MEM/WB.
REQ-008 MemResult_In  input  DATA_W  load data carried through MEM/WB.
REQ-009 LinkAddr_In  input  DATA_W  return address for jump-and-link write-back.
REQ-010 WriteBackRegAddr_In  input  5  destination register index.
REQ-011 ReadAddrA_In, ReadAddrB_In  input  5 each  decode-stage source register indices.
REQ-012 ReadDataA_Out, ReadDataB_Out  output  DATA_W each  source operand values.
REQ-013 WriteBackData_Out  output  DATA_W  selected write-back value, used by the forwarding unit.
REQ-014 WriteCount_Out  output  32  count of committed register writes.

Function
REQ-015 WriteBackData_Out SHALL be combinational from the write-back inputs: ALUResult_In for 00, MemResult_In for 01, LinkAddr_In for 10, ALUResult_In for 11.
REQ-016 A write SHALL be effective when RESET=0, RegWriteEN_In=1 and WriteBackRegAddr_In!=0.
REQ-017 On an effective write, register[WriteBackRegAddr_In] SHALL take WriteBackData_Out at the next rising edge (1-cycle write latency).
REQ-018 Register 0 SHALL always read 0; writes to it SHALL be discarded and SHALL NOT be counted.
REQ-019 Read ports SHALL be combinational, with zero-cycle latency from the read address to the read data.
REQ-020 Same-cycle bypass: if a read address equals WriteBackRegAddr_In, that address is nonzero and RegWriteEN_In=1, the read port SHALL return WriteBackData_Out rather than the stored value.
REQ-021 Both read ports MAY address the same register; both SHALL return identical data, and both SHALL be bypassed when REQ-020 applies.
REQ-022 RegWriteEN_In=0 SHALL leave all storage and WriteCount_Out unchanged, regardless of the other write-back inputs.
REQ-023 WriteCount_Out SHALL increment by 1 on each effective write and wrap from 0xFFFFFFFF to 0 without flagging.
REQ-024 Consecutive effective writes to the same register on back-to-back cycles SHALL each commit in order; the last write wins.

Reset
REQ-025 While RESET=1 at a rising edge, all registers and WriteCount_Out SHALL be cleared to 0.
REQ-026 RESET SHALL take priority over a simultaneous write; that write is lost and is not counted.
REQ-027 While RESET=1, ReadDataA_Out and ReadDataB_Out SHALL be 0 and bypass SHALL be suppressed; WriteBackData_Out still follows REQ-015.
REQ-028 The first effective write after RESET deasserts SHALL commit normally, with no dead cycle.

Structure
REQ-029 A shared package SHALL hold the Mem2RegSEL encodings (WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10), REG_ZERO=5'd0 and the register-address width constant; the pipeline registers and control unit SHALL use the same package.
REQ-030 The write-back source multiplexer SHALL be a separate combinational sub-module, wb_select; storage, bypass and counter logic SHALL stay in wb_regfile.
REQ-031 Storage SHALL be a flop array with no memory-macro inference dependency.

Verification
REQ-032 Reset then read all 32 registers -> all 0; WriteCount_Out=0.
REQ-033 Write 0xDEADBEEF to r5 with SEL=00 and EN=1, then read r5 on the next cycle -> 0xDEADBEEF; WriteCount_Out=1.
REQ-034 Same cycle: EN=1, addr r7, SEL=01, MemResult=0x12345678, ReadAddrA=r7 -> ReadDataA_Out=0x12345678 before the edge; stored value matches after the edge.
REQ-035 Write 0xFFFFFFFF to r0 with EN=1 -> reads of r0 return 0, no bypass, WriteCount_Out unchanged.
REQ-036 RESET=1 with a simultaneous write of 0x55 to r3 -> r3=0 and WriteCount_Out=0; SEL=10 with LinkAddr=0x00400008 to r31 -> r31=0x00400008.
REQ-037 Preload WriteCount_Out near wrap via 0xFFFFFFFF effective writes (or force) and write once more -> WriteCount_Out=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared write-back encodings and register-address constants for the integer pipeline.
package wb_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned COUNT_W    = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_select.sv
// Write-back source multiplexer; the reserved encoding falls back to the ALU result.
module wb_select
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [WB_SEL_W-1:0] sel,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic [DATA_W-1:0]   link_addr,
  output logic [DATA_W-1:0]   wb_data_c
);

  always_comb begin
    wb_data_c = alu_result;
    case (wb_sel_e'(sel))
      WB_SEL_MEM:  wb_data_c = mem_result;
      WB_SEL_LINK: wb_data_c = link_addr;
      default:     wb_data_c = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with write-back source select, same-cycle read bypass
// and a committed-write counter. r0 is hardwired to zero.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  RegWriteEN_In,
  input  logic [WB_SEL_W-1:0]   Mem2RegSEL_In,
  input  logic [DATA_W-1:0]     ALUResult_In,
  input  logic [DATA_W-1:0]     MemResult_In,
  input  logic [DATA_W-1:0]     LinkAddr_In,
  input  logic [REG_ADDR_W-1:0] WriteBackRegAddr_In,
  input  logic [REG_ADDR_W-1:0] ReadAddrA_In,
  input  logic [REG_ADDR_W-1:0] ReadAddrB_In,
  output logic [DATA_W-1:0]     ReadDataA_Out,
  output logic [DATA_W-1:0]     ReadDataB_Out,
  output logic [DATA_W-1:0]     WriteBackData_Out,
  output logic [COUNT_W-1:0]    WriteCount_Out
);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [COUNT_W-1:0] write_count;
  logic [DATA_W-1:0]  wb_data_c;
  logic               wr_en_c;

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .sel        (Mem2RegSEL_In),
    .alu_result (ALUResult_In),
    .mem_result (MemResult_In),
    .link_addr  (LinkAddr_In),
    .wb_data_c  (wb_data_c)
  );

  assign WriteBackData_Out = wb_data_c;
  assign WriteCount_Out    = write_count;

  // Writes to r0 are dropped here so they neither store nor count nor bypass.
  assign wr_en_c = RegWriteEN_In && (WriteBackRegAddr_In != REG_ZERO);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (wr_en_c) begin
      regs[WriteBackRegAddr_In] <= wb_data_c;
      write_count               <= write_count + COUNT_W'(1);
    end
  end

  // Read ports: zero under reset or for r0, otherwise bypass an in-flight write.
  always_comb begin
    ReadDataA_Out = '0;
    ReadDataB_Out = '0;
    if (!RESET) begin
      if (ReadAddrA_In != REG_ZERO) begin
        ReadDataA_Out = (wr_en_c && (ReadAddrA_In == WriteBackRegAddr_In))
                        ? wb_data_c : regs[ReadAddrA_In];
      end
      if (ReadAddrB_In != REG_ZERO) begin
        ReadDataB_Out = (wr_en_c && (ReadAddrB_In == WriteBackRegAddr_In))
                        ? wb_data_c : regs[ReadAddrB_In];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        RegWriteEN_In;
  logic [1:0]  Mem2RegSEL_In;
  logic [31:0] ALUResult_In;
  logic [31:0] MemResult_In;
  logic [31:0] LinkAddr_In;
  logic [4:0]  WriteBackRegAddr_In;
  logic [4:0]  ReadAddrA_In;
  logic [4:0]  ReadAddrB_In;
  logic [31:0] ReadDataA_Out;
  logic [31:0] ReadDataB_Out;
  logic [31:0] WriteBackData_Out;
  logic [31:0] WriteCount_Out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLOCK = ~CLOCK;

  wb_regfile #(.NUM_REGS(32), .DATA_W(32)) dut (
    .CLOCK               (CLOCK),
    .RESET               (RESET),
    .RegWriteEN_In       (RegWriteEN_In),
    .Mem2RegSEL_In       (Mem2RegSEL_In),
    .ALUResult_In        (ALUResult_In),
    .MemResult_In        (MemResult_In),
    .LinkAddr_In         (LinkAddr_In),
    .WriteBackRegAddr_In (WriteBackRegAddr_In),
    .ReadAddrA_In        (ReadAddrA_In),
    .ReadAddrB_In        (ReadAddrB_In),
    .ReadDataA_Out       (ReadDataA_Out),
    .ReadDataB_Out       (ReadDataB_Out),
    .WriteBackData_Out   (WriteBackData_Out),
    .WriteCount_Out      (WriteCount_Out)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteEN_In       = 1'b0;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'h0;
    MemResult_In        = 32'h0;
    LinkAddr_In         = 32'h0;
    WriteBackRegAddr_In = 5'd0;
  endtask

  task automatic test_reset();
    RESET               = 1'b1;
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'hCAFE_0001;
    MemResult_In        = 32'h0;
    LinkAddr_In         = 32'h0;
    WriteBackRegAddr_In = 5'd3;
    ReadAddrA_In        = 5'd3;
    ReadAddrB_In        = 5'd3;
    tick();
    tick();
    n_cmp++;
    if (ReadDataA_Out !== 32'h0) begin
      n_err++; $display("FAIL reset_no_bypass_a: got %h want %h", ReadDataA_Out, 32'h0);
    end
    n_cmp++;
    if (WriteBackData_Out !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL reset_wbdata: got %h want %h", WriteBackData_Out, 32'hCAFE_0001);
    end
    idle_inputs();
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      ReadAddrA_In = 5'(i);
      ReadAddrB_In = 5'(31 - i);
      #1;
      n_cmp++;
      if (ReadDataA_Out !== 32'h0 || ReadDataB_Out !== 32'h0) begin
        n_err++; $display("FAIL reset_clear r%0d: got %h/%h want 0", i, ReadDataA_Out, ReadDataB_Out);
      end
    end
    n_cmp++;
    if (WriteCount_Out !== 32'h0) begin
      n_err++; $display("FAIL reset_count: got %h want %h", WriteCount_Out, 32'h0);
    end
  endtask

  task automatic test_write_read();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'hDEAD_BEEF;
    MemResult_In        = 32'h1111_2222;
    WriteBackRegAddr_In = 5'd5;
    ReadAddrA_In        = 5'd1;
    tick();
    idle_inputs();
    ReadAddrA_In = 5'd5;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL write_read_r5: got %h want %h", ReadDataA_Out, 32'hDEAD_BEEF);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'd1) begin
      n_err++; $display("FAIL write_read_count: got %h want %h", WriteCount_Out, 32'd1);
    end
  endtask

  task automatic test_bypass();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b01;
    ALUResult_In        = 32'h0BAD_0BAD;
    MemResult_In        = 32'h1234_5678;
    WriteBackRegAddr_In = 5'd7;
    ReadAddrA_In        = 5'd7;
    ReadAddrB_In        = 5'd7;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h1234_5678) begin
      n_err++; $display("FAIL bypass_a: got %h want %h", ReadDataA_Out, 32'h1234_5678);
    end
    n_cmp++;
    if (ReadDataB_Out !== 32'h1234_5678) begin
      n_err++; $display("FAIL bypass_b: got %h want %h", ReadDataB_Out, 32'h1234_5678);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h1234_5678) begin
      n_err++; $display("FAIL bypass_stored: got %h want %h", ReadDataA_Out, 32'h1234_5678);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'd2) begin
      n_err++; $display("FAIL bypass_count: got %h want %h", WriteCount_Out, 32'd2);
    end
  endtask

  task automatic test_reg_zero();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'hFFFF_FFFF;
    WriteBackRegAddr_In = 5'd0;
    ReadAddrA_In        = 5'd0;
    ReadAddrB_In        = 5'd0;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h0) begin
      n_err++; $display("FAIL r0_no_bypass: got %h want %h", ReadDataA_Out, 32'h0);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (ReadDataB_Out !== 32'h0) begin
      n_err++; $display("FAIL r0_stored: got %h want %h", ReadDataB_Out, 32'h0);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'd2) begin
      n_err++; $display("FAIL r0_count: got %h want %h", WriteCount_Out, 32'd2);
    end
  endtask

  task automatic test_no_enable();
    RegWriteEN_In       = 1'b0;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'h1111_1111;
    WriteBackRegAddr_In = 5'd5;
    ReadAddrA_In        = 5'd5;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL noen_no_bypass: got %h want %h", ReadDataA_Out, 32'hDEAD_BEEF);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'hDEAD_BEEF || WriteCount_Out !== 32'd2) begin
      n_err++; $display("FAIL noen_unchanged: got %h cnt %h want %h cnt %h",
                        ReadDataA_Out, WriteCount_Out, 32'hDEAD_BEEF, 32'd2);
    end
  endtask

  task automatic test_sel_reserved();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b11;
    ALUResult_In        = 32'hA5A5_A5A5;
    MemResult_In        = 32'h5A5A_5A5A;
    LinkAddr_In         = 32'h0000_0004;
    WriteBackRegAddr_In = 5'd9;
    #1;
    n_cmp++;
    if (WriteBackData_Out !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL sel11_wbdata: got %h want %h", WriteBackData_Out, 32'hA5A5_A5A5);
    end
    tick();
    idle_inputs();
    ReadAddrB_In = 5'd9;
    #1;
    n_cmp++;
    if (ReadDataB_Out !== 32'hA5A5_A5A5 || WriteCount_Out !== 32'd3) begin
      n_err++; $display("FAIL sel11_stored: got %h cnt %h want %h cnt %h",
                        ReadDataB_Out, WriteCount_Out, 32'hA5A5_A5A5, 32'd3);
    end
  endtask

  task automatic test_back_to_back();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    WriteBackRegAddr_In = 5'd10;
    ALUResult_In        = 32'h0000_0001;
    tick();
    ALUResult_In        = 32'h0000_0002;
    tick();
    idle_inputs();
    ReadAddrA_In = 5'd10;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h0000_0002) begin
      n_err++; $display("FAIL b2b_last_wins: got %h want %h", ReadDataA_Out, 32'h0000_0002);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'd5) begin
      n_err++; $display("FAIL b2b_count: got %h want %h", WriteCount_Out, 32'd5);
    end
  endtask

  task automatic test_reset_priority();
    RESET               = 1'b1;
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'h0000_0055;
    WriteBackRegAddr_In = 5'd3;
    ReadAddrA_In        = 5'd3;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h0) begin
      n_err++; $display("FAIL rstpri_read_zero: got %h want %h", ReadDataA_Out, 32'h0);
    end
    tick();
    RESET = 1'b0;
    idle_inputs();
    ReadAddrB_In = 5'd5;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h0 || ReadDataB_Out !== 32'h0) begin
      n_err++; $display("FAIL rstpri_cleared: got r3 %h r5 %h want 0", ReadDataA_Out, ReadDataB_Out);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'h0) begin
      n_err++; $display("FAIL rstpri_count: got %h want %h", WriteCount_Out, 32'h0);
    end
  endtask

  task automatic test_link_after_reset();
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b10;
    ALUResult_In        = 32'h7777_7777;
    MemResult_In        = 32'h8888_8888;
    LinkAddr_In         = 32'h0040_0008;
    WriteBackRegAddr_In = 5'd31;
    tick();
    idle_inputs();
    ReadAddrA_In = 5'd31;
    #1;
    n_cmp++;
    if (ReadDataA_Out !== 32'h0040_0008) begin
      n_err++; $display("FAIL link_r31: got %h want %h", ReadDataA_Out, 32'h0040_0008);
    end
    n_cmp++;
    if (WriteCount_Out !== 32'd1) begin
      n_err++; $display("FAIL link_count: got %h want %h", WriteCount_Out, 32'd1);
    end
  endtask

  task automatic test_wrap();
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    #1;
    n_cmp++;
    if (WriteCount_Out !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_preload: got %h want %h", WriteCount_Out, 32'hFFFF_FFFF);
    end
    RegWriteEN_In       = 1'b1;
    Mem2RegSEL_In       = 2'b00;
    ALUResult_In        = 32'h0000_0007;
    WriteBackRegAddr_In = 5'd4;
    tick();
    idle_inputs();
    ReadAddrB_In = 5'd4;
    #1;
    n_cmp++;
    if (WriteCount_Out !== 32'h0) begin
      n_err++; $display("FAIL wrap_count: got %h want %h", WriteCount_Out, 32'h0);
    end
    n_cmp++;
    if (ReadDataB_Out !== 32'h0000_0007) begin
      n_err++; $display("FAIL wrap_r4: got %h want %h", ReadDataB_Out, 32'h0000_0007);
    end
  endtask

  initial begin
    RESET        = 1'b1;
    ReadAddrA_In = 5'd0;
    ReadAddrB_In = 5'd0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_reg_zero();
    test_no_enable();
    test_sel_reserved();
    test_back_to_back();
    test_reset_priority();
    test_link_after_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
